// File: rtl/riscv_main_controller_if.sv
// riscv_main_controller_if
// Bus between the decode stage (master: supplies the opcode) and the main
// controller (slave: returns the registered control bundle).
// Optional macro CTRL_ILLEGAL_OPCODE_EN adds the registered 'illegal' flag.
interface riscv_main_controller_if;
  logic [6:0] opcode;
  logic [3:0] aluOp;
  logic       exec_a;
  logic       exec_b;
  logic       mem_w;
  logic       reg_w;
  logic       mem2reg;
  logic       bra;
  logic       jmp;
`ifdef CTRL_ILLEGAL_OPCODE_EN
  logic       illegal;
`endif

  modport master (
    output opcode,
    input  aluOp, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp
`ifdef CTRL_ILLEGAL_OPCODE_EN
    , input illegal
`endif
  );

  modport slave (
    input  opcode,
    output aluOp, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp
`ifdef CTRL_ILLEGAL_OPCODE_EN
    , output illegal
`endif
  );
endinterface

// File: rtl/riscv_main_controller.sv
// riscv_main_controller
// RV32I main decoder: maps the 7-bit opcode to the datapath control bundle
// {aluOp[3:0], exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp}, registered
// so it lines up with the decode/execute pipeline register (1-cycle latency).
// Optional macro CTRL_ILLEGAL_OPCODE_EN adds a registered 'illegal' flag that
// is set for any opcode outside the eleven recognised ones.
module riscv_main_controller (
  input  logic                          clk,
  input  logic                          rst_n,
  riscv_main_controller_if.slave        ctrl
);

  // Full 7-bit opcode encodings.
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_J       = 7'b1101111;
  localparam logic [6:0] OP_I_JUMP  = 7'b1100111;
  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_I_SYS   = 7'b1110011;
  localparam logic [6:0] OP_I_FENCE = 7'b0001111;

  // ALU operation classes, refined later by the ALU control unit.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_RTYPE  = 4'b0001,
    ALU_IARITH = 4'b0010,
    ALU_BRCMP  = 4'b0011,
    ALU_PASS_B = 4'b0100
  } alu_class_e;

  // Field order is the bundle word order, MSB first.
  typedef struct packed {
    alu_class_e alu_op;
    logic       exec_a;
    logic       exec_b;
    logic       mem_w;
    logic       reg_w;
    logic       mem2reg;
    logic       bra;
    logic       jmp;
  } ctrl_bundle_t;

  ctrl_bundle_t bundle_d, bundle_q;
`ifdef CTRL_ILLEGAL_OPCODE_EN
  logic illegal_d, illegal_q;
`endif

  // Combinational opcode decode into the next bundle value.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would infer a latch; unrecognised opcodes fall through to 0x000.
    bundle_d        = '0;
    bundle_d.alu_op = ALU_ADD;
`ifdef CTRL_ILLEGAL_OPCODE_EN
    illegal_d       = 1'b0;
`endif
    case (ctrl.opcode)
      OP_R: begin
        bundle_d.alu_op = ALU_RTYPE;
        bundle_d.reg_w  = 1'b1;
      end
      OP_I_ARITH: begin
        bundle_d.alu_op = ALU_IARITH;
        bundle_d.exec_b = 1'b1;
        bundle_d.reg_w  = 1'b1;
      end
      OP_I_LOAD: begin
        bundle_d.exec_b  = 1'b1;
        bundle_d.reg_w   = 1'b1;
        bundle_d.mem2reg = 1'b1;
      end
      OP_S: begin
        bundle_d.exec_b = 1'b1;
        bundle_d.mem_w  = 1'b1;
      end
      OP_B: begin
        // Compare uses rs1/rs2; the branch target adder is elsewhere.
        bundle_d.alu_op = ALU_BRCMP;
        bundle_d.bra    = 1'b1;
      end
      OP_J: begin
        bundle_d.exec_a = 1'b1;
        bundle_d.exec_b = 1'b1;
        bundle_d.reg_w  = 1'b1;
        bundle_d.jmp    = 1'b1;
      end
      OP_I_JUMP: begin
        bundle_d.exec_b = 1'b1;
        bundle_d.reg_w  = 1'b1;
        bundle_d.jmp    = 1'b1;
      end
      OP_U_LUI: begin
        bundle_d.alu_op = ALU_PASS_B;
        bundle_d.exec_b = 1'b1;
        bundle_d.reg_w  = 1'b1;
      end
      OP_U_AUIPC: begin
        bundle_d.exec_a = 1'b1;
        bundle_d.exec_b = 1'b1;
        bundle_d.reg_w  = 1'b1;
      end
      OP_I_SYS, OP_I_FENCE: begin
        // Recognised, but no datapath side effects.
      end
      default: begin
`ifdef CTRL_ILLEGAL_OPCODE_EN
        illegal_d = 1'b1;
`endif
      end
    endcase
  end

  // Output register: captures the decode every rising edge, cleared async.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all registers update together from
    // values sampled before the edge, avoiding simulation ordering races.
    if (!rst_n) begin
      bundle_q  <= '0;
`ifdef CTRL_ILLEGAL_OPCODE_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      bundle_q  <= bundle_d;
`ifdef CTRL_ILLEGAL_OPCODE_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign ctrl.aluOp   = bundle_q.alu_op;
  assign ctrl.exec_a  = bundle_q.exec_a;
  assign ctrl.exec_b  = bundle_q.exec_b;
  assign ctrl.mem_w   = bundle_q.mem_w;
  assign ctrl.reg_w   = bundle_q.reg_w;
  assign ctrl.mem2reg = bundle_q.mem2reg;
  assign ctrl.bra     = bundle_q.bra;
  assign ctrl.jmp     = bundle_q.jmp;
`ifdef CTRL_ILLEGAL_OPCODE_EN
  assign ctrl.illegal = illegal_q;
`endif

endmodule

// File: tb/tb_riscv_main_controller.sv
// tb_riscv_main_controller
// Self-checking bench for riscv_main_controller. The reference model is a
// plain opcode -> bundle lookup table taken from the decode table.
// Build with +define+CTRL_ILLEGAL_OPCODE_EN to also check the 'illegal' flag.
module tb_riscv_main_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  riscv_main_controller_if bus();

  riscv_main_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: the eleven recognised opcodes and their bundle values.
  logic [6:0]  ref_op  [11];
  logic [10:0] ref_val [11];

  initial begin
    ref_op[0]  = 7'b0110011; ref_val[0]  = 11'h088;
    ref_op[1]  = 7'b0010011; ref_val[1]  = 11'h128;
    ref_op[2]  = 7'b0000011; ref_val[2]  = 11'h02C;
    ref_op[3]  = 7'b0100011; ref_val[3]  = 11'h030;
    ref_op[4]  = 7'b1100011; ref_val[4]  = 11'h182;
    ref_op[5]  = 7'b1101111; ref_val[5]  = 11'h069;
    ref_op[6]  = 7'b1100111; ref_val[6]  = 11'h029;
    ref_op[7]  = 7'b0110111; ref_val[7]  = 11'h228;
    ref_op[8]  = 7'b0010111; ref_val[8]  = 11'h068;
    ref_op[9]  = 7'b1110011; ref_val[9]  = 11'h000;
    ref_op[10] = 7'b0001111; ref_val[10] = 11'h000;
  end

  function automatic logic [10:0] model_bundle(input logic [6:0] op);
    for (int i = 0; i < 11; i++)
      if (ref_op[i] == op) return ref_val[i];
    return 11'h000;
  endfunction

  function automatic logic model_legal(input logic [6:0] op);
    for (int i = 0; i < 11; i++)
      if (ref_op[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [10:0] dut_bundle();
    return {bus.aluOp, bus.exec_a, bus.exec_b, bus.mem_w, bus.reg_w,
            bus.mem2reg, bus.bra, bus.jmp};
  endfunction

  // Drive a new opcode on the falling edge, then sample 1 ns after the next
  // rising edge.
  task automatic apply_op(input logic [6:0] op);
    @(negedge clk);
    bus.opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bundle(input string name, input logic [6:0] op,
                              input logic [10:0] exp);
    checks++;
    if (dut_bundle() !== exp) begin
      failures++;
      $display("FAIL %s op=%b got=0x%03h exp=0x%03h", name, op, dut_bundle(), exp);
    end
`ifdef CTRL_ILLEGAL_OPCODE_EN
    checks++;
    if (bus.illegal !== !model_legal(op)) begin
      failures++;
      $display("FAIL %s_illegal op=%b got=%b exp=%b", name, op, bus.illegal,
               !model_legal(op));
    end
`endif
  endtask

  task automatic check_invariants(input string name, input logic [6:0] op);
    checks++;
    if ((bus.mem_w && bus.reg_w) || (bus.bra && bus.jmp) ||
        (bus.mem2reg && !bus.reg_w)) begin
      failures++;
      $display("FAIL %s op=%b got mem_w=%b reg_w=%b bra=%b jmp=%b mem2reg=%b exp invariants hold",
               name, op, bus.mem_w, bus.reg_w, bus.bra, bus.jmp, bus.mem2reg);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.opcode = 7'b0110011;
    #1;
    checks++;
    if (dut_bundle() !== 11'h000) begin
      failures++;
      $display("FAIL reset_initial got=0x%03h exp=0x000", dut_bundle());
    end
    // Leave reset and load a non-zero bundle.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bundle("reset_release", 7'b0110011, 11'h088);
    // Assert reset mid-cycle: outputs clear with no clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bundle("reset_async", 7'b0000000, 11'h000);
    @(posedge clk);
    #1;
    check_bundle("reset_hold", 7'b0000000, 11'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bundle("reset_first_decode", 7'b0110011, 11'h088);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 11; i++) begin
      apply_op(ref_op[i]);
      check_bundle("sweep", ref_op[i], ref_val[i]);
    end
  endtask

  task automatic test_latency();
    apply_op(7'b0000011);
    check_bundle("latency_load", 7'b0000011, 11'h02C);
    @(negedge clk);
    bus.opcode = 7'b0100011;
    #1;
    check_bundle("latency_hold", 7'b0000011, 11'h02C);
    @(posedge clk);
    #1;
    check_bundle("latency_store", 7'b0100011, 11'h030);
  endtask

  task automatic test_illegal();
    logic [6:0] ill [3];
    ill[0] = 7'b0000000;
    ill[1] = 7'b1111111;
    ill[2] = 7'b0110010;
    for (int i = 0; i < 3; i++) begin
      apply_op(ill[i]);
      check_bundle("illegal_op", ill[i], 11'h000);
    end
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 128; i++) begin
      logic [6:0] op;
      op = 7'(i);
      apply_op(op);
      check_bundle("exhaustive", op, model_bundle(op));
      check_invariants("invariant", op);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      if ($urandom_range(1, 0) == 1) op = ref_op[$urandom_range(10, 0)];
      else                           op = 7'($urandom);
      apply_op(op);
      check_bundle("random", op, model_bundle(op));
      check_invariants("random_invariant", op);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sweep();
    test_latency();
    test_illegal();
    test_exhaustive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the run is short and clock-driven; this only guards a stall.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
